fetch_decode_queue: RTL and testbench
=====================================

// Module: fetch_decode_queue
// PURPOSE
// - Instruction queue between the fetch stage and the decode stage of the pipeline.
// - Captures each fetched instruction with its PC+8 value in a small circular FIFO and presents the oldest entry to decode.
// - Decouples fetch from decode stalls: fetch stalls only when the queue is full.
// - Flushed on taken branch / PC redirect so wrong-path instructions never reach decode.
// PARAMETERS
// - N      32  instruction / address width
// - DEPTH  4   entry count; power of 2, >= 2
// PORTS
// - clk       in   1        rising-edge clock
// - rst       in   1        asynchronous, active-low reset (0 = reset)
// - InstrF    in   N        instruction word from instruction memory
// - PCPlus8F  in   N        PC+8 value produced by fetch for InstrF
// - ValidF    in   1        InstrF/PCPlus8F valid this cycle
// - ReadyF    out  1        queue can accept; fetch drives StallF = !ReadyF
// - FlushD    in   1        discard all entries (branch taken / PCSrcW redirect)
// - InstrD    out  N        head instruction to decode
// - PCPlus8D  out  N        head PC+8 to decode register file
// - ValidD    out  1        InstrD/PCPlus8D valid
// - ReadyD    in   1        decode accepts head (decode drives !StallD)
// - CountQ    out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
// - Reset (rst=0, async): rd_ptr=wr_ptr=0, CountQ=0, ValidD=0, InstrD=0, PCPlus8D=0, ReadyF=1; storage contents don't care.
// - push = ValidF & ReadyF; pop = ValidD & ReadyD; both evaluated at the clk rising edge.
// - ReadyF = (CountQ != DEPTH); depends on registered count only, no combinational path from ReadyD.
// - ValidD = (CountQ != 0); InstrD/PCPlus8D = head entry when ValidD, else 0 (NOP).
// - push: write entry at wr_ptr, wr_ptr += 1 mod DEPTH. pop: rd_ptr += 1 mod DEPTH.
// - CountQ: +1 push only, -1 pop only, unchanged on push&pop.
// - Latency: instruction pushed at edge k is visible on InstrD after edge k (next cycle); 1-cycle minimum.
// - Full: ReadyF=0; ValidF ignored even if pop occurs same cycle; ReadyF returns 1 the cycle after the pop.
// - Empty: ValidD=0; ReadyD ignored; a push makes ValidD=1 the next cycle.
// - Pointers wrap modulo DEPTH with no gap; order strictly FIFO.
// - FlushD=1 (synchronous): rd_ptr=wr_ptr=0, CountQ=0 next cycle; push and pop in the same cycle are discarded.
// - FlushD has priority over push and pop.
// - Reset asserted mid-operation: all state returns to reset values immediately, regardless of clk.
// - Outputs are stable while ReadyD=0: head entry is held unchanged until popped or flushed.
// CONFIGURATION
// - FDQ_BYPASS_EN defined:
//   - when CountQ==0 and ValidF=1 and FlushD=0: ValidD=1, InstrD=InstrF, PCPlus8D=PCPlus8F combinationally (0-cycle latency).
//   - if ReadyD=1 in that cycle, the instruction is consumed directly and not written (CountQ stays 0).
//   - if ReadyD=0, it is written normally.
// - FDQ_BYPASS_EN undefined: no bypass; ValidD is 0 whenever CountQ==0; 1-cycle minimum latency.
// TESTING
// - Reset: rst=0 mid-run with CountQ=3 -> CountQ=0, ValidD=0, ReadyF=1, InstrD=0 without a clock edge.
// - Fill: ReadyD=0, push 0xE0810002,0xE2411001,0xE1A00000,0xEAFFFFFE (PCPlus8F 8,12,16,20) -> CountQ=4, ReadyF=0;
//   a 5th push with ValidF=1 is not accepted.
// - Drain/wrap: after fill, ReadyD=1 with ValidF=1 streaming 0x100+i -> output order 0xE0810002.. then 0x100..;
//   FIFO order holds after pointer wrap; steady push&pop keeps CountQ constant.
// - Flush: CountQ=3, FlushD=1 with ValidF=1 and ReadyD=1 same cycle -> next cycle CountQ=0, ValidD=0;
//   flushed entries and the same-cycle push never appear on InstrD.
// - Stall hold: head 0xE3A00005, ReadyD=0 for 5 cycles -> InstrD/PCPlus8D unchanged each cycle, CountQ unchanged.
// - Bypass (FDQ_BYPASS_EN): empty queue, ValidF=1, InstrF=0xE3A01007, ReadyD=1 -> same cycle ValidD=1,
//   InstrD=0xE3A01007, CountQ stays 0.
//   Without the macro: ValidD=0 that cycle and ValidD=1 the next.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//
// Instruction queue between the fetch and decode stages. Each fetched
// instruction is stored with its PC+8 value in a small circular FIFO, and the
// oldest entry is presented to decode. Fetch stalls only when the queue is
// full. A flush (taken branch / PC redirect) empties the queue so wrong-path
// instructions never reach decode.
//
// Optional feature: define FDQ_BYPASS_EN to let an instruction arriving at an
// empty queue appear on the decode outputs in the same cycle. If decode takes
// it in that cycle, it is never written into storage.
//
// Parameters
//   N      instruction / address width
//   DEPTH  number of entries (power of 2, >= 2)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset (0 = reset)
//   InstrF    in   instruction word from instruction memory
//   PCPlus8F  in   PC+8 value belonging to InstrF
//   ValidF    in   InstrF/PCPlus8F valid this cycle
//   ReadyF    out  queue can accept (fetch stalls when low)
//   FlushD    in   discard every entry, including a same-cycle push
//   InstrD    out  head instruction (0 when not valid)
//   PCPlus8D  out  head PC+8 (0 when not valid)
//   ValidD    out  InstrD/PCPlus8D valid
//   ReadyD    in   decode accepts the head this cycle
//   CountQ    out  current occupancy
module fetch_decode_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             InstrF,
    input  logic [N-1:0]             PCPlus8F,
    input  logic                     ValidF,
    output logic                     ReadyF,
    input  logic                     FlushD,
    output logic [N-1:0]             InstrD,
    output logic [N-1:0]             PCPlus8D,
    output logic                     ValidD,
    input  logic                     ReadyD,
    output logic [$clog2(DEPTH):0]   CountQ
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Storage is never reset: an entry is only read after it has been written.
    logic [N-1:0]  instr_mem_q [DEPTH];
    logic [N-1:0]  pc_mem_q    [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic not_empty;
    logic bypass_act;
    logic push;
    logic pop;

    assign not_empty = (count_q != '0);

    // Registered count only, so there is no combinational path ReadyD -> ReadyF.
    assign ReadyF = (count_q != FULL_C);

`ifdef FDQ_BYPASS_EN
    assign bypass_act = !not_empty && ValidF && !FlushD;
`else
    assign bypass_act = 1'b0;
`endif

    // A bypassed instruction taken by decode in the same cycle is not stored.
    assign push = ValidF && ReadyF && !(bypass_act && ReadyD);
    assign pop  = not_empty && ReadyD;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (FlushD) begin
            // Flush wins over any push or pop in the same cycle.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !FlushD) begin
            instr_mem_q[wr_ptr_q] <= InstrF;
            pc_mem_q[wr_ptr_q]    <= PCPlus8F;
        end
    end

    // Outputs are driven to zero (NOP) whenever nothing valid is presented.
    always_comb begin
        ValidD   = 1'b0;
        InstrD   = '0;
        PCPlus8D = '0;
        if (not_empty) begin
            ValidD   = 1'b1;
            InstrD   = instr_mem_q[rd_ptr_q];
            PCPlus8D = pc_mem_q[rd_ptr_q];
        end else if (bypass_act) begin
            ValidD   = 1'b1;
            InstrD   = InstrF;
            PCPlus8D = PCPlus8F;
        end
    end

    assign CountQ = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue (N=32, DEPTH=4).
// The stimulus process keeps a reference occupancy and a queue of expected
// entries; a monitor on the falling edge compares the DUT against them.
module tb_fetch_decode_queue;

    localparam int N     = 32;
    localparam int DEPTH = 4;
`ifdef FDQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  InstrF, PCPlus8F, InstrD, PCPlus8D;
    logic          ValidF, ReadyF, FlushD, ValidD, ReadyD;
    logic [2:0]    CountQ;

    fetch_decode_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .InstrF   (InstrF),
        .PCPlus8F (PCPlus8F),
        .ValidF   (ValidF),
        .ReadyF   (ReadyF),
        .FlushD   (FlushD),
        .InstrD   (InstrD),
        .PCPlus8D (PCPlus8D),
        .ValidD   (ValidD),
        .ReadyD   (ReadyD),
        .CountQ   (CountQ)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cnt      = 0;   // reference occupancy during the current cycle
    int nc       = 0;   // reference occupancy after the next edge
    logic [63:0] expq[$];   // {instr, pc+8} in expected decode order

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus the reference-model update.
    task automatic cycle(input bit vf, input logic [N-1:0] ins, input logic [N-1:0] pc,
                         input bit rdy, input bit fl);
        bit acc, byp;
        @(posedge clk);
        cnt = nc;
        #1;
        ValidF = vf; InstrF = ins; PCPlus8F = pc; ReadyD = rdy; FlushD = fl;
        byp = BYP && (cnt == 0) && vf && !fl;
        if (fl) begin
            expq.delete();
            nc = 0;
        end else begin
            acc = vf && (cnt != DEPTH);
            if (acc) expq.push_back({ins, pc});
            nc = cnt + int'(acc) - int'(rdy && cnt != 0) - int'(byp && rdy);
        end
    endtask

    // Monitor: falling edge, inputs and outputs settled.
    always @(negedge clk) begin
        bit exp_v;
        if (rst === 1'b1) begin
            exp_v = (cnt != 0) || (BYP && ValidF && !FlushD);
            chk("CountQ", 64'(CountQ), 64'(cnt));
            chk("ReadyF", 64'(ReadyF), 64'(cnt != DEPTH));
            chk("ValidD", 64'(ValidD), 64'(exp_v));
            if (!exp_v) begin
                chk("InstrD_nop", 64'(InstrD), 64'd0);
            end else if (!FlushD && ValidD) begin
                if (expq.size() == 0) begin
                    chk("unexpected_head", 64'(InstrD), 64'hDEAD_BEEF_0000_0000);
                end else begin
                    chk("InstrD", 64'(InstrD), 64'(expq[0][63:32]));
                    chk("PCPlus8D", 64'(PCPlus8D), 64'(expq[0][31:0]));
                    if (ReadyD) void'(expq.pop_front());
                end
            end
        end
    end

    logic [N-1:0] fill_i [4];

    initial begin
        fill_i[0] = 32'hE0810002; fill_i[1] = 32'hE2411001;
        fill_i[2] = 32'hE1A00000; fill_i[3] = 32'hEAFFFFFE;
        rst = 1'b0; ValidF = 1'b0; InstrF = '0; PCPlus8F = '0; ReadyD = 1'b0; FlushD = 1'b0;
        #2;
        chk("rst_CountQ", 64'(CountQ), 64'd0);
        chk("rst_ValidD", 64'(ValidD), 64'd0);
        chk("rst_ReadyF", 64'(ReadyF), 64'd1);
        chk("rst_InstrD", 64'(InstrD), 64'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Fill with decode stalled; fifth push must be refused.
        for (int i = 0; i < 4; i++) cycle(1, fill_i[i], 32'(8 + 4 * i), 0, 0);
        cycle(1, 32'hBADBAD00, 32'h0, 0, 0);
        cycle(0, 32'h0, 32'h0, 0, 0);

        // Drain while streaming: order must survive pointer wrap.
        for (int i = 0; i < 12; i++) cycle(1, 32'(32'h100 + i), 32'(32'h200 + 4 * i), 1, 0);
        for (int i = 0; i < 6; i++) cycle(0, 32'h0, 32'h0, 1, 0);

        // Stall hold on a single head entry.
        cycle(1, 32'hE3A00005, 32'h40, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 32'h0, 32'h0, 0, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Flush with three entries plus simultaneous push and pop.
        for (int i = 0; i < 3; i++) cycle(1, 32'(32'hF00 + i), 32'(32'h300 + 4 * i), 0, 0);
        cycle(1, 32'hF0F0F0F0, 32'h3F0, 1, 1);
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Empty queue, push with decode ready (bypass or one-cycle latency).
        cycle(1, 32'hE3A01007, 32'h50, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Randomised traffic with phases of heavy and light decode stalls.
        for (int i = 0; i < 400; i++) begin
            bit vf, rdy, fl;
            vf  = ($urandom_range(0, 3) != 0);
            rdy = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            cycle(vf, $urandom, $urandom, rdy, fl);
        end
        for (int i = 0; i < 6; i++) cycle(0, 32'h0, 32'h0, 1, 0);

        // Asynchronous reset between edges with three entries held.
        for (int i = 0; i < 3; i++) cycle(1, 32'(32'hA00 + i), 32'(32'h400 + 4 * i), 0, 0);
        cycle(0, 32'h0, 32'h0, 0, 0);
        chk("pre_reset_CountQ", 64'(CountQ), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_CountQ", 64'(CountQ), 64'd0);
        chk("async_ValidD", 64'(ValidD), 64'd0);
        chk("async_ReadyF", 64'(ReadyF), 64'd1);
        chk("async_InstrD", 64'(InstrD), 64'd0);
        expq.delete(); cnt = 0; nc = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cycle(1, 32'h12345678, 32'h60, 0, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        @(posedge clk);
        #2;
        chk("final_queue_empty", 64'(expq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
